// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the mem_copy_dma engine:
//   dma_state_t      - engine state encoding (IDLE, READ, WRITE, FIN)
//   WORD_BYTES       - byte stride between consecutive 32-bit words
//   is_word_aligned  - true when the two byte-offset bits of an address are 0
// -----------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } dma_state_t;

    localparam int WORD_BYTES = 4;

    // Only the byte-offset bits matter for word alignment.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage : dma_pkg

// File: rtl/mem_copy_dma_if.sv
// -----------------------------------------------------------------------------
// mem_copy_dma_if
// Single-port word memory bus (one-cycle registered read).
//   mem_addr      byte address, initiator -> memory
//   mem_wdata     write data,   initiator -> memory
//   mem_write_en  write strobe, initiator -> memory
//   mem_read_en   read strobe,  initiator -> memory
//   mem_rdata     read data,    memory -> initiator, valid the cycle after a
//                 read strobe and held until the next read
// Modports: master (the DMA engine), slave (the memory).
// -----------------------------------------------------------------------------
interface mem_copy_dma_if #(
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write_en,
        output mem_read_en,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write_en,
        input  mem_read_en,
        output mem_rdata
    );

endinterface : mem_copy_dma_if

// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
// Memory-to-memory copy / constant-fill engine driving a single-port word
// memory as bus initiator.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         command strobe, only honoured in IDLE
//   fill          0 = copy src->dst, 1 = fill dst with fill_data
//   src_addr      copy source byte address
//   dst_addr      destination byte address
//   len_words     number of 32-bit words to move
//   fill_data     fill pattern
//   busy          high while the engine is in READ or WRITE
//   done          one-cycle completion pulse
//   err           one-cycle pulse with done when the command was rejected
//   mem           memory bus (master side)
//
// A copy alternates READ / WRITE per word; a fill issues one WRITE per cycle.
// Misaligned or empty commands go straight to FIN without touching memory.
// -----------------------------------------------------------------------------
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 fill,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len_words,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    mem_copy_dma_if.master       mem
);

    localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    dma_state_t        state_q;
    logic              fill_q;
    logic [31:0]       fill_data_q;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [LEN_W-1:0]  count_q;
    logic              err_q;

    logic              cmd_bad_s;
    logic              cmd_empty_s;

    // Command validation; the source alignment only matters when copying.
    always_comb begin
        cmd_bad_s   = 1'b0;
        cmd_empty_s = 1'b0;
        if ((!fill && !is_word_aligned(src_addr[1:0])) ||
            !is_word_aligned(dst_addr[1:0])) begin
            cmd_bad_s = 1'b1;
        end else begin
            cmd_bad_s = 1'b0;
        end
        if (len_words == LEN_ZERO) begin
            cmd_empty_s = 1'b1;
        end else begin
            cmd_empty_s = 1'b0;
        end
    end

    // Engine FSM with command capture, pointer and word-count datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= 1'b0;
            fill_data_q <= 32'h0000_0000;
            src_ptr_q   <= ADDR_ZERO;
            dst_ptr_q   <= ADDR_ZERO;
            count_q     <= LEN_ZERO;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fill_q      <= fill;
                        fill_data_q <= fill_data;
                        src_ptr_q   <= src_addr;
                        dst_ptr_q   <= dst_addr;
                        count_q     <= len_words;
                        err_q       <= cmd_bad_s;
                        if (cmd_bad_s || cmd_empty_s) begin
                            state_q <= FIN;
                        end else if (fill) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    // Pointers wrap silently at the top of the address space.
                    src_ptr_q <= src_ptr_q + PTR_STEP;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    dst_ptr_q <= dst_ptr_q + PTR_STEP;
                    count_q   <= count_q - LEN_ONE;
                    if (count_q == LEN_ONE) begin
                        state_q <= FIN;
                    end else if (fill_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= READ;
                    end
                end
                FIN: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; copy write data passes straight
    // through from the memory's registered read port.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        err              = 1'b0;
        mem.mem_addr     = ADDR_ZERO;
        mem.mem_wdata    = 32'h0000_0000;
        mem.mem_write_en = 1'b0;
        mem.mem_read_en  = 1'b0;
        case (state_q)
            READ: begin
                busy            = 1'b1;
                mem.mem_read_en = 1'b1;
                mem.mem_addr    = src_ptr_q;
            end
            WRITE: begin
                busy             = 1'b1;
                mem.mem_write_en = 1'b1;
                mem.mem_addr     = dst_ptr_q;
                if (fill_q) begin
                    mem.mem_wdata = fill_data_q;
                end else begin
                    mem.mem_wdata = mem.mem_rdata;
                end
            end
            FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule : mem_copy_dma

// File: tb/tb_mem_copy_dma.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_dma
// Self-checking bench for mem_copy_dma. A behavioural RAM answers the bus; a
// reference model (associative array of word contents plus the cycle timing
// rules of the engine) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fill;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        err;

    mem_copy_dma_if #(.ADDR_W(32)) bus ();

    mem_copy_dma #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fill      (fill),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 16K words indexed by addr[15:2], registered read.
    logic [31:0] ram [0:16383];
    logic [31:0] rdata_r;
    logic        bd_we;
    logic [13:0] bd_idx;
    logic [31:0] bd_data;

    assign bus.mem_rdata = rdata_r;

    // RAM write port (backdoor preload or DUT) and registered read port.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end else if (bus.mem_write_en) begin
            ram[bus.mem_addr[15:2]] <= bus.mem_wdata;
        end
        if (bus.mem_read_en) begin
            rdata_r <= ram[bus.mem_addr[15:2]];
        end
    end

    // Reference memory contents, keyed by word index.
    logic [31:0] model [int];

    int errors = 0;
    int checks = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[15:2]);
    endfunction

    function automatic logic [68:0] observe();
        return {busy, done, err, bus.mem_read_en, bus.mem_write_en,
                bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = addr[15:2];
        bd_data = data;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
        model[widx(addr)] = data;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        foreach (model[k]) begin
            if (ram[k] !== model[k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_%s: %0d words differ from reference, expected 0", name, bad);
        end
    endtask

    // Issue one command and check every cycle up to and including the first
    // idle cycle after done. With hold=1 start stays high (and the command
    // inputs churn) until the cycle after done.
    task automatic run_cmd(input string name, input bit f, input logic [31:0] s,
                           input logic [31:0] d, input logic [15:0] n,
                           input logic [31:0] fd, input bit hold);
        bit          mis;
        int          total;
        int          k;
        logic [68:0] exp_v;
        logic [68:0] obs_v;
        logic        e_busy, e_done, e_err, e_re, e_we;
        logic [31:0] e_addr, e_data;
        mis   = (!f && s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        total = (mis || n == 16'd0) ? 1 : (f ? int'(n) + 1 : 2 * int'(n) + 1);
        @(negedge clk);
        fill = f; src_addr = s; dst_addr = d; len_words = n; fill_data = fd;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            if (!hold || c == total + 1) begin
                start = 1'b0;
            end else begin
                fill = 1'($urandom); src_addr = $urandom; dst_addr = $urandom;
                len_words = 16'($urandom); fill_data = $urandom;
            end
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_re = 1'b0; e_we = 1'b0;
            e_addr = 32'h0; e_data = 32'h0;
            if (c == total) begin
                e_done = 1'b1;
                e_err  = mis;
            end else if (c < total) begin
                e_busy = 1'b1;
                if (f) begin
                    k = c - 1;
                    e_we = 1'b1; e_addr = d + 32'(4 * k); e_data = fd;
                    model[widx(e_addr)] = fd;
                end else begin
                    k = (c - 1) / 2;
                    if (c % 2 == 1) begin
                        e_re = 1'b1; e_addr = s + 32'(4 * k);
                    end else begin
                        e_data = model[widx(s + 32'(4 * k))];
                        e_we = 1'b1; e_addr = d + 32'(4 * k);
                        model[widx(e_addr)] = e_data;
                    end
                end
            end
            exp_v = {e_busy, e_done, e_err, e_re, e_we, e_addr, e_data};
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got busy/done/err/re/we=%b addr=%h wdata=%h, expected %b addr=%h wdata=%h",
                         name, c, obs_v[68:64], obs_v[63:32], obs_v[31:0],
                         exp_v[68:64], exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [68:0] obs_v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs_v = observe();
        checks++;
        if (obs_v !== 69'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, expected 0", obs_v);
        end
        rst = 1'b0;
        @(negedge clk);
        obs_v = observe();
        checks++;
        if (obs_v !== 69'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h, expected 0", obs_v);
        end
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) poke(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        poke(32'h210, 32'h5A5A_0210);
        run_cmd("copy4", 1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 1'b0);
        check_mem("copy4");
    endtask

    task automatic test_fill();
        poke(32'h4C, 32'h1234_5678);
        run_cmd("fill3", 1'b1, 32'h0, 32'h40, 16'd3, 32'hDEAD_BEEF, 1'b0);
        check_mem("fill3");
    endtask

    task automatic test_misaligned();
        run_cmd("mis_src", 1'b0, 32'h102, 32'h300, 16'd3, 32'h0, 1'b0);
        run_cmd("mis_dst", 1'b1, 32'h0, 32'h302, 16'd2, 32'h1111_2222, 1'b0);
        run_cmd("len0", 1'b0, 32'h100, 32'h300, 16'd0, 32'h0, 1'b0);
        // A misaligned source is irrelevant in fill mode.
        run_cmd("fill_src_ignored", 1'b1, 32'h103, 32'h500, 16'd1, 32'h0BAD_CAFE, 1'b0);
        check_mem("misaligned");
    endtask

    task automatic test_reset_midcopy();
        logic [68:0] obs_v;
        logic [68:0] exp_v;
        for (int i = 0; i < 4; i++) poke(32'h600 + 32'(4 * i), 32'hB0 + 32'(i));
        poke(32'h704, 32'h7777_0704);
        @(negedge clk);
        fill = 1'b0; src_addr = 32'h600; dst_addr = 32'h700; len_words = 16'd4;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            case (c)
                1:       exp_v = {5'b10010, 32'h600, 32'h0};
                2:       exp_v = {5'b10001, 32'h700, 32'hB0};
                3:       exp_v = {5'b10010, 32'h604, 32'h0};
                default: exp_v = 69'd0;
            endcase
            if (c == 2) model[widx(32'h700)] = 32'hB0;
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_midcopy cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
        end
        check_mem("reset_midcopy");
        run_cmd("copy_after_reset", 1'b0, 32'h600, 32'h700, 16'd4, 32'h0, 1'b0);
        check_mem("copy_after_reset");
    endtask

    task automatic test_hold_start_wrap();
        run_cmd("wrap_fill_hold", 1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'hCAFE_F00D, 1'b1);
        for (int i = 0; i < 2; i++) poke(32'h800 + 32'(4 * i), $urandom);
        run_cmd("copy_hold", 1'b0, 32'h800, 32'h900, 16'd2, 32'h0, 1'b1);
        check_mem("hold_wrap");
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) poke(32'(4 * i), 32'(i + 1));
        run_cmd("overlap", 1'b0, 32'h0, 32'h4, 16'd3, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[i] !== 32'd1) begin
                errors++;
                $display("FAIL overlap_word%0d: got %h, expected 00000001", i, ram[i]);
            end
        end
    endtask

    task automatic test_random();
        bit          f;
        logic [31:0] s, d;
        logic [15:0] n;
        for (int i = 0; i < 10; i++) begin
            f = 1'($urandom);
            n = 16'($urandom_range(0, 5));
            s = 32'h1000 + 32'(4 * $urandom_range(0, 63));
            d = 32'h2000 + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) s = s + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) d = d + 32'($urandom_range(1, 3));
            if (!f && s[1:0] == 2'b00 && d[1:0] == 2'b00) begin
                for (int j = 0; j < int'(n); j++) poke(s + 32'(4 * j), $urandom);
            end
            run_cmd($sformatf("rand%0d", i), f, s, d, n, $urandom, 1'($urandom));
        end
        check_mem("random");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fill = 1'b0;
        src_addr = 32'h0; dst_addr = 32'h0; len_words = 16'h0; fill_data = 32'h0;
        bd_we = 1'b0; bd_idx = 14'h0; bd_data = 32'h0;
        test_reset();
        test_copy();
        test_fill();
        test_misaligned();
        test_reset_midcopy();
        test_hold_start_wrap();
        test_overlap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_copy_dma

// File: doc/mem_copy_dma.md
# mem_copy_dma

Bus initiator that drives the single-port word memory interface (addr / wdata / write_en / read_en / rdata, one-cycle registered read). Software or the bring-up sequencer programs a source address, destination address and word count. The engine then either copies words from source to destination or fills the destination with a constant pattern. It is the master-side counterpart of the on-chip RAM and connects directly to its port in place of, or muxed with, the CPU data port.

## Interface
- ADDR_W, 32, byte-address width of the memory bus
- LEN_W, 16, width of the word-count field

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- fill  in  1  mode, captured with start: 0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source byte address, captured with start
- dst_addr  in  ADDR_W  destination byte address, captured with start
- len_words  in  LEN_W  number of 32-bit words, captured with start
- fill_data  in  32  fill pattern, captured with start
- busy  out  1  high in READ/WRITE states
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on rejected command
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  32  write data to memory
- mem_write_en  out  1  write strobe
- mem_read_en  out  1  read strobe
- mem_rdata  in  32  read data, valid the cycle after a read_en cycle, held until the next read

## Operation
- States: IDLE, READ, WRITE, FIN.
- **IDLE:**
  - start=1 captures all command inputs and loads src_ptr, dst_ptr and remaining count.
  - If src_addr[1:0]≠0 (copy only) or dst_addr[1:0]≠0: go to FIN with err set.
  - Else if len_words=0: go to FIN.
  - Else copy goes to READ, fill goes to WRITE.
- **READ:** mem_read_en=1, mem_addr=src_ptr. src_ptr += 4. Go to WRITE.
- **WRITE:** mem_write_en=1, mem_addr=dst_ptr, mem_wdata = mem_rdata (copy) or fill_data register (fill). dst_ptr += 4, count −= 1.
  - If count was 1: go to FIN.
  - Else copy goes to READ, fill stays in WRITE.
- **FIN:** done=1 (and err=1 if flagged), then go to IDLE.
- start outside IDLE is ignored, including in FIN.
- Read and write strobes are never asserted in the same cycle.
- mem_addr=0, mem_wdata=0 and both strobes are 0 whenever the engine is not in READ/WRITE.
- Pointers add 4 modulo 2^ADDR_W, so wrap 0xFFFF_FFFC→0x0000_0000 silently.
- Overlapping regions are copied strictly word-by-word in ascending order; no overlap detection.
- The engine only issues byte addresses. The memory uses addr[15:2]; aliasing above that range is the system's concern.

## Timing
- Reset: state=IDLE; busy, done, err, mem_read_en, mem_write_en = 0; mem_addr, mem_wdata = 0; internal pointers and count = 0.
- rst asserted mid-transfer: IDLE at the next edge, strobes low from that cycle, no done pulse. Partial writes remain in memory.
- Outputs are decoded from registered state and pointers; mem_wdata in copy mode is a direct path from mem_rdata.
- Cycle numbering: cycle 1 is the cycle after the edge that samples start.
- Copy of N words: word k read in cycle 2k+1 and written in cycle 2k+2; done in cycle 2N+1.
- Fill of N words: word k written in cycle k+1; done in cycle N+1.
- len=0 or misaligned command: done (and err) in cycle 1, no memory strobes.
- The earliest next start is sampled in the cycle after done.

## Structure
- Shared package dma_pkg holds:
  - state enum dma_state_t {IDLE, READ, WRITE, FIN}
  - WORD_BYTES=4
  - alignment-check helper
- Single module, no sub-module. The pointer/count datapath is small enough to keep inline.

## Test plan
- Copy 4 words, src 0x100 preloaded with 0xA0..0xA3, dst 0x200 → 0x200..0x20C hold 0xA0..0xA3; done in cycle 9; busy high cycles 1–8.
- Fill 3 words at 0x40 with 0xDEADBEEF → three consecutive write cycles (1–3), done cycle 4, 0x4C untouched.
- Misaligned src 0x102 in copy mode → done and err in cycle 1, no read_en/write_en ever asserted; repeat with len=0 → done without err.
- Reset asserted in cycle 3 of a 4-word copy → only word 0 written, state IDLE and all strobes low next cycle, no done; a new start then completes normally.
- start held high during a transfer and in FIN → ignored; dst 0xFFFF_FFFC, 2-word fill → writes to 0xFFFF_FFFC then 0x0000_0000.
- Overlapping copy src=0x0, dst=0x4, N=3, memory 1,2,3,4 → memory becomes 1,1,1,1.
